// File: rtl/name_serializer_if.sv
// Handshake bundle for name_serializer: the name-offer channel from upstream,
// the component stream to the lookup stage, and the completed-name counter.
// The DUT attaches through the slave modport, the producer/consumer through master.
interface name_serializer_if #(
  parameter int unsigned WORD_SIZE         = 32,
  parameter int unsigned MAX_NAME_LENGTH   = 8,
  parameter int unsigned STRIDE_INDEX_SIZE = 3
);

  logic                                 name_valid_in;
  logic                                 name_ready_out;
  logic [MAX_NAME_LENGTH*WORD_SIZE-1:0] name_words_in;
  logic [3:0]                           name_len_in;

  logic                                 comp_valid_out;
  logic                                 comp_ready_in;
  logic [WORD_SIZE-1:0]                 comp_word_out;
  logic [STRIDE_INDEX_SIZE-1:0]         comp_index_out;
  logic                                 comp_first_out;
  logic                                 comp_last_out;
  logic [15:0]                          names_done_out;

  modport slave (
    input  name_valid_in,
    input  name_words_in,
    input  name_len_in,
    input  comp_ready_in,
    output name_ready_out,
    output comp_valid_out,
    output comp_word_out,
    output comp_index_out,
    output comp_first_out,
    output comp_last_out,
    output names_done_out
  );

  modport master (
    output name_valid_in,
    output name_words_in,
    output name_len_in,
    output comp_ready_in,
    input  name_ready_out,
    input  comp_valid_out,
    input  comp_word_out,
    input  comp_index_out,
    input  comp_first_out,
    input  comp_last_out,
    input  names_done_out
  );

endinterface

// File: rtl/name_serializer.sv
// name_serializer: buffers up to two multi-word names in a ping-pong store and
// streams each one out as component words, highest slot first, with index and
// first/last markers, counting fully streamed names.
// Optional feature: define NAME_SER_PAD_EN to pad every nonzero-length name to
// MAX_NAME_LENGTH beats, with zero words beyond the clamped length.
module name_serializer #(
  parameter int unsigned WORD_SIZE         = 32,
  parameter int unsigned MAX_NAME_LENGTH   = 8,
  parameter int unsigned STRIDE_INDEX_SIZE = 3
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  name_serializer_if.slave    bus
);

  localparam int unsigned    LEN_W   = 4;
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_NAME_LENGTH);

  typedef enum logic {
    ST_EMPTY,
    ST_STREAM
  } state_t;

  state_t                       state;
  state_t                       state_next;

  // Words are stored already reversed: entry k is component k of the name.
  logic [WORD_SIZE-1:0]         buf_words [2][MAX_NAME_LENGTH];
  logic [LEN_W-1:0]             buf_len   [2];

  logic                         wr_ptr;
  logic                         rd_ptr;
  logic [1:0]                   occ;
  logic [1:0]                   occ_next;
  logic                         ready_en;
  logic [STRIDE_INDEX_SIZE-1:0] rd_idx;
  logic [15:0]                  done_cnt;

  logic [LEN_W-1:0]             len_clamped;
  logic [LEN_W-1:0]             beats;
  logic                         name_ready;
  logic                         accept;
  logic                         store;
  logic                         at_last;
  logic                         xfer;
  logic                         xfer_last;
  logic [WORD_SIZE-1:0]         cur_word;

  logic                         comp_valid;
  logic                         comp_first;
  logic                         comp_last;
  logic [WORD_SIZE-1:0]         comp_word;

  assign len_clamped = (bus.name_len_in > MAX_LEN) ? MAX_LEN : bus.name_len_in;

  // ready_en keeps the write side closed during reset and until the first edge after it.
  assign name_ready  = ready_en & (occ != 2'd2);
  assign accept      = bus.name_valid_in & name_ready;
  // Zero-length names complete the handshake but never occupy a buffer slot.
  assign store       = accept & (len_clamped != '0);

`ifdef NAME_SER_PAD_EN
  assign beats = MAX_LEN;
`else
  assign beats = buf_len[rd_ptr];
`endif

  assign at_last   = (32'(rd_idx) + 32'd1) == 32'(beats);
  assign xfer      = comp_valid & bus.comp_ready_in;
  assign xfer_last = xfer & comp_last;

  // Select the component word for the current index.
  always_comb begin
    cur_word = buf_words[rd_ptr][rd_idx];
`ifdef NAME_SER_PAD_EN
    if (32'(rd_idx) >= 32'(buf_len[rd_ptr])) begin
      cur_word = '0;
    end
`endif
  end

  // Occupancy after this edge: one in on store, one out on last-beat transfer.
  always_comb begin
    occ_next = occ;
    case ({store, xfer_last})
      2'b10:   occ_next = occ + 2'd1;
      2'b01:   occ_next = occ - 2'd1;
      default: occ_next = occ;
    endcase
  end

  // Capture an accepted name into the write-side slot, reversing word order.
  always_ff @(posedge clk_in) begin
    if (store) begin
      buf_len[wr_ptr] <= len_clamped;
      for (int unsigned k = 0; k < MAX_NAME_LENGTH; k++) begin
        buf_words[wr_ptr][k] <= bus.name_words_in[(MAX_NAME_LENGTH-1-k)*WORD_SIZE +: WORD_SIZE];
      end
    end
  end

  // Ping-pong pointers, occupancy and write-side enable.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      occ      <= '0;
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      occ      <= occ_next;
      if (store) begin
        wr_ptr <= ~wr_ptr;
      end
      if (xfer_last) begin
        rd_ptr <= ~rd_ptr;
      end
    end
  end

  // Read-side state register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // Next state: start streaming as soon as a name lands; stop only when the
  // final beat leaves with nothing else buffered, otherwise roll straight on.
  always_comb begin
    state_next = state;
    case (state)
      ST_EMPTY: begin
        if (store) begin
          state_next = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (xfer_last && (occ_next == '0)) begin
          state_next = ST_EMPTY;
        end
      end
      default: state_next = ST_EMPTY;
    endcase
  end

  // Component index and completed-name counter.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rd_idx   <= '0;
      done_cnt <= '0;
    end else if (xfer) begin
      if (at_last) begin
        rd_idx   <= '0;
        done_cnt <= done_cnt + 16'd1;
      end else begin
        rd_idx   <= rd_idx + STRIDE_INDEX_SIZE'(1);
      end
    end
  end

  // Stream outputs are decoded from registered state only, so they hold under
  // backpressure and drop to zero the instant reset asserts.
  always_comb begin
    comp_valid = 1'b0;
    comp_first = 1'b0;
    comp_last  = 1'b0;
    comp_word  = '0;
    if (state == ST_STREAM) begin
      comp_valid = 1'b1;
      comp_first = (rd_idx == '0);
      comp_last  = at_last;
      comp_word  = cur_word;
    end
  end

  assign bus.name_ready_out = name_ready;
  assign bus.comp_valid_out = comp_valid;
  assign bus.comp_word_out  = comp_word;
  assign bus.comp_index_out = rd_idx;
  assign bus.comp_first_out = comp_first;
  assign bus.comp_last_out  = comp_last;
  assign bus.names_done_out = done_cnt;

endmodule

// File: doc/name_serializer.md
NAME_SERIALIZER -- requirements
Module: name_serializer

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 32: width of one name component word.
REQ-002 SHALL have parameter MAX_NAME_LENGTH, default 8: maximum number of words in one name.
REQ-003 SHALL have parameter STRIDE_INDEX_SIZE, default 3: width of the component index.
REQ-004 SHALL have port clk_in, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n_in, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port name_valid_in, input, 1 bit: upstream offers a name.
REQ-007 SHALL have port name_ready_out, output, 1 bit: a buffer slot is free.
REQ-008 SHALL have port name_words_in, input, MAX_NAME_LENGTH*WORD_SIZE bits: slot j is bits [j*WORD_SIZE +: WORD_SIZE].
REQ-009 SHALL have port name_len_in, input, 4 bits: number of valid words in the name.
REQ-010 SHALL have port comp_valid_out, output, 1 bit: a component word is presented.
REQ-011 SHALL have port comp_ready_in, input, 1 bit: the downstream lookup stage accepts the word.
REQ-012 SHALL have port comp_word_out, output, WORD_SIZE bits: the current component.
REQ-013 SHALL have port comp_index_out, output, STRIDE_INDEX_SIZE bits: position of the component within its name, 0-based.
REQ-014 SHALL have ports comp_first_out and comp_last_out, output, 1 bit each: mark the first and last beat of a name.
REQ-015 SHALL have port names_done_out, output, 16 bits: count of names fully streamed; wraps from 0xFFFF to 0.

Function
REQ-016 A name SHALL be accepted on a rising edge where name_valid_in and name_ready_out are both 1.
REQ-017 name_ready_out SHALL be 1 iff fewer than 2 names are buffered; it SHALL NOT depend combinationally on comp_ready_in.
REQ-018 The buffer SHALL be a 2-entry ping-pong store with write pointer, read pointer and occupancy 0..2.
REQ-019 A beat SHALL transfer on a rising edge where comp_valid_out and comp_ready_in are both 1.
REQ-020 While comp_valid_out=1 and comp_ready_in=0, all comp_* outputs SHALL hold stable.
REQ-021 Component k SHALL be taken from slot MAX_NAME_LENGTH-1-k, so the highest slot is emitted first.
REQ-022 name_len_in values above MAX_NAME_LENGTH SHALL be clamped to MAX_NAME_LENGTH.
REQ-023 A name with name_len_in=0 SHALL be accepted and discarded: no beats are produced and names_done_out is unchanged.
REQ-024 The read side SHALL be a state machine with two states:
- EMPTY to STREAM when occupancy becomes nonzero.
- STREAM to EMPTY after the last beat transfers with no other name buffered.
- STREAM to STREAM (next name at index 0) after the last beat transfers with another name buffered; no gap cycle.
REQ-025 Latency: a name accepted at edge N into an empty buffer SHALL present comp_valid_out=1 with index 0 after edge N.
REQ-026 An accept and a last-beat transfer in the same cycle SHALL both take effect; occupancy is unchanged.
REQ-027 comp_first_out SHALL be 1 iff the index is 0; comp_last_out SHALL be 1 iff the index is (beats per name - 1).
REQ-028 names_done_out SHALL increment on each transferred last beat.

Reset
REQ-029 Asserting rst_n_in low SHALL immediately clear the following, including mid-name, discarding all buffered names:
- occupancy and both pointers to 0; state to EMPTY.
- comp_valid_out, comp_first_out, comp_last_out, comp_index_out to 0.
- comp_word_out to 0; names_done_out to 0.
REQ-030 While rst_n_in is low, name_ready_out SHALL be 0; it SHALL be 1 from the first edge after deassertion.

Configuration
REQ-031 With macro NAME_SER_PAD_EN defined, every nonzero-length name SHALL emit exactly MAX_NAME_LENGTH beats; beats with index >= clamped length carry word 0.
REQ-032 Without NAME_SER_PAD_EN, a name SHALL emit exactly its clamped length in beats.

Verification
REQ-033 Basic stream: name len=3, slots 7..5 = 0xA1,0xA2,0xA3, comp_ready_in held 1 -> beats 0xA1/idx0/first, 0xA2/idx1, 0xA3/idx2/last on 3 consecutive cycles; names_done_out=1.
REQ-034 Back-to-back: two len=8 names offered continuously -> 16 beats with no bubble; name_ready_out drops to 0 only when 2 names are held.
REQ-035 Backpressure: comp_ready_in=0 for 5 cycles at idx 2 -> word, idx and flags constant; stream resumes at idx 2.
REQ-036 Boundaries: len=0 -> no beats, counter unchanged; len=12 -> 8 beats; padding with NAME_SER_PAD_EN, len=2 -> 8 beats with idx 2..7 = 0, last at idx 7.
REQ-037 Reset mid-operation: rst_n_in low at idx 4 of a name with a second name buffered -> all outputs 0 at once; no stale beat after release.
REQ-038 Wrap: preload names_done_out near 0xFFFF, stream 2 names -> 0xFFFF then 0x0000.
